// File: rtl/bsg_nasti_r_burst_arb.sv
// Round-robin arbiter merging per-source NASTI R beats onto one R channel.
// A multi-beat burst locks the winning source until its last beat is accepted.
module bsg_nasti_r_burst_arb #(
   parameter int num_src_p    = 4,
   parameter int id_width_p   = 5,
   parameter int data_width_p = 64,
   parameter int max_beats_p  = 8
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_src_p-1:0]                src_valid_i,
   input  logic [num_src_p*id_width_p-1:0]     src_id_i,
   input  logic [num_src_p*data_width_p-1:0]   src_data_i,
   input  logic [num_src_p-1:0]                src_last_i,
   output logic [num_src_p-1:0]                src_yumi_o,
   output logic                                nasti_r_valid_o,
   output logic [id_width_p-1:0]               nasti_r_id_o,
   output logic [data_width_p-1:0]             nasti_r_data_o,
   output logic                                nasti_r_last_o,
   output logic [1:0]                          nasti_r_resp_o,
   input  logic                                nasti_r_ready_i,
   output logic [num_src_p-1:0]                grant_o,
   output logic                                busy_o,
   output logic                                error_o
);

   localparam int SrcW  = $clog2(num_src_p);
   localparam int SrcW1 = SrcW + 1;
   localparam int BeatW = $clog2(max_beats_p);
   localparam logic [SrcW:0]    NumSrc  = SrcW1'(num_src_p);
   localparam logic [SrcW-1:0]  LastSrc = SrcW'(num_src_p - 1);
   localparam logic [BeatW-1:0] BeatMax = BeatW'(max_beats_p - 1);

   typedef enum logic {IDLE, BURST} state_e;

   state_e           state_q,   state_d;
   logic [SrcW-1:0]  rrPtr_q,   rrPtr_d;
   logic [SrcW-1:0]  lockSrc_q, lockSrc_d;
   logic [BeatW-1:0] beatCnt_q, beatCnt_d;
   logic             error_q,   error_d;

   logic             arbFound;
   logic [SrcW-1:0]  arbIdx;
   logic [SrcW:0]    candWide;
   logic [SrcW-1:0]  cand;
   logic             grantAny;
   logic [SrcW-1:0]  grantIdx;
   logic             handshake;

   function automatic logic [SrcW-1:0] nextIdx(input logic [SrcW-1:0] idx);
      return (idx == LastSrc) ? '0 : idx + SrcW'(1);
   endfunction

   // Rotating priority search starting at rrPtr_q, wrapping past the top source
   always_comb begin
      arbFound = 1'b0;
      arbIdx   = '0;
      candWide = '0;
      cand     = '0;
      for (int k = 0; k < num_src_p; k++) begin
         candWide = {1'b0, rrPtr_q} + SrcW1'(k);
         if (candWide >= NumSrc) candWide = candWide - NumSrc;
         cand = candWide[SrcW-1:0];
         if (!arbFound && src_valid_i[cand]) begin
            arbFound = 1'b1;
            arbIdx   = cand;
         end
      end
   end

   // Reset gates the grant so nothing leaks out while the block is held in reset
   always_comb begin
      if (state_q == BURST) begin
         grantAny = 1'b1;
         grantIdx = lockSrc_q;
      end else begin
         grantAny = arbFound;
         grantIdx = arbIdx;
      end
      grantAny = grantAny & reset_n_i;
   end

   always_comb begin
      grant_o        = '0;
      nasti_r_id_o   = '0;
      nasti_r_data_o = '0;
      nasti_r_last_o = 1'b0;
      for (int i = 0; i < num_src_p; i++) begin
         if (grantAny && (grantIdx == SrcW'(i))) begin
            grant_o[i]     = 1'b1;
            nasti_r_id_o   = src_id_i[i*id_width_p +: id_width_p];
            nasti_r_data_o = src_data_i[i*data_width_p +: data_width_p];
            nasti_r_last_o = src_last_i[i];
         end
      end
   end

   assign nasti_r_valid_o = |(grant_o & src_valid_i);
   assign src_yumi_o      = grant_o & src_valid_i & {num_src_p{nasti_r_ready_i}};
   assign nasti_r_resp_o  = 2'b00;
   assign handshake       = nasti_r_valid_o & nasti_r_ready_i;
   assign busy_o          = (state_q == BURST);
   assign error_o         = error_q;

   // Overlength bursts flag the error but keep the lock until the real last beat
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      lockSrc_d = lockSrc_q;
      beatCnt_d = beatCnt_q;
      error_d   = error_q;
      if (handshake) begin
         if (state_q == IDLE) begin
            if (nasti_r_last_o) begin
               rrPtr_d = nextIdx(grantIdx);
            end else begin
               state_d   = BURST;
               lockSrc_d = grantIdx;
               beatCnt_d = BeatW'(1);
            end
         end else if (nasti_r_last_o) begin
            state_d   = IDLE;
            rrPtr_d   = nextIdx(lockSrc_q);
            beatCnt_d = '0;
         end else if (beatCnt_q == BeatMax) begin
            error_d = 1'b1;
         end else begin
            beatCnt_d = beatCnt_q + BeatW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         rrPtr_q   <= '0;
         lockSrc_q <= '0;
         beatCnt_q <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         lockSrc_q <= lockSrc_d;
         beatCnt_q <= beatCnt_d;
         error_q   <= error_d;
      end
   end

endmodule

// File: doc/bsg_nasti_r_burst_arb.md
BSG_NASTI_R_BURST_ARB -- requirements
Module: bsg_nasti_r_burst_arb

Interface
REQ-001 The block SHALL have parameter num_src_p, default 4, giving the number of response sources (2..16).
REQ-002 The block SHALL have parameter id_width_p, default 5, giving the NASTI R id width.
REQ-003 The block SHALL have parameter data_width_p, default 64, giving the NASTI R data width.
REQ-004 The block SHALL have parameter max_beats_p, default 8, giving the maximum legal beats per burst (power of two, >=2).
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n_i  input  1  reset, asynchronous assert, active-low, synchronous deassert by the system.
REQ-007 src_valid_i  input  num_src_p  per-source beat valid.
REQ-008 src_id_i  input  num_src_p*id_width_p  per-source id, source i in slice i.
REQ-009 src_data_i  input  num_src_p*data_width_p  per-source data, source i in slice i.
REQ-010 src_last_i  input  num_src_p  per-source last-beat flag.
REQ-011 src_yumi_o  output  num_src_p  per-source beat consumed.
REQ-012 nasti_r_valid_o  output  1  R channel valid.
REQ-013 nasti_r_id_o / nasti_r_data_o / nasti_r_last_o  output  id_width_p / data_width_p / 1  R channel fields.
REQ-014 nasti_r_resp_o  output  2  R channel response code.
REQ-015 nasti_r_ready_i  input  1  R channel ready.
REQ-016 grant_o  output  num_src_p  one-hot current grant, zero when none.
REQ-017 busy_o  output  1  high while a burst is locked.
REQ-018 error_o  output  1  sticky burst-overlength error.

Function
REQ-019 The block SHALL implement states IDLE and BURST, plus registers rr_ptr (log2 num_src_p), lock_src (log2 num_src_p), beat_cnt (log2 max_beats_p).
REQ-020 In IDLE, grant SHALL go to the first source with valid asserted searching upward from rr_ptr, wrapping at num_src_p-1 to 0; grant SHALL be zero if no source is valid.
REQ-021 In BURST, grant SHALL go to lock_src only; other sources' valid SHALL be ignored and their yumi held 0.
REQ-022 nasti_r_valid_o SHALL equal the valid of the granted source, combinationally (zero added latency).
REQ-023 nasti_r_id_o, nasti_r_data_o, nasti_r_last_o SHALL be the granted source's fields, and all-zero when grant is zero.
REQ-024 nasti_r_resp_o SHALL be constant 2'b00 (OKAY).
REQ-025 src_yumi_o[i] SHALL equal grant[i] & src_valid_i[i] & nasti_r_ready_i; at most one bit high per cycle.
REQ-026 A handshake is a cycle with nasti_r_valid_o & nasti_r_ready_i; no state SHALL change in cycles without a handshake.
REQ-027 IDLE handshake with last=1: remain IDLE, rr_ptr <= granted index + 1 mod num_src_p.
REQ-028 IDLE handshake with last=0: go to BURST, lock_src <= granted index, beat_cnt <= 1.
REQ-029 BURST handshake with last=1: go to IDLE, rr_ptr <= lock_src + 1 mod num_src_p, beat_cnt <= 0.
REQ-030 BURST handshake with last=0 and beat_cnt < max_beats_p-1: beat_cnt increments.
REQ-031 BURST handshake with last=0 and beat_cnt == max_beats_p-1: error_o SHALL set and beat_cnt SHALL saturate; state remains BURST and lock is kept until last.
REQ-032 error_o SHALL clear only on reset.
REQ-033 busy_o SHALL be high exactly in BURST.
REQ-034 Deassertion of a locked source's valid mid-burst SHALL NOT release the lock; R valid drops until that source resumes.
REQ-035 Wrap-around: rr_ptr increment from num_src_p-1 SHALL yield 0.

Reset
REQ-036 While reset_n_i is low, the block SHALL asynchronously force state=IDLE, rr_ptr=0, lock_src=0, beat_cnt=0, error_o=0.
REQ-037 During reset, src_yumi_o, grant_o, busy_o, nasti_r_valid_o SHALL be 0 regardless of inputs.
REQ-038 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from source 0.

Verification
REQ-039 Sources 0..3 all valid, last=1, ready=1, 4 cycles -> grant_o 0001,0010,0100,1000; rr_ptr wraps to 0.
REQ-040 Source 1 sends 4-beat burst (last on beat 4), source 2 valid throughout -> yumi only to 1 for 4 handshakes, busy_o high beats 1-3 and 0 after, then source 2 granted.
REQ-041 Burst on source 0 with ready=0 for 3 cycles between beats -> no yumi, beat_cnt unchanged, data held stable on R.
REQ-042 Source 3 sends 9 non-last beats with max_beats_p=8 -> error_o rises at the 8th handshake, stays high; lock held until last.
REQ-043 Reset_n_i pulsed low asynchronously during beat 2 of a burst on source 2 -> outputs 0 immediately; after release, sources 0 and 2 valid -> source 0 granted.
REQ-044 Locked source 1 drops valid 2 cycles mid-burst while source 0 valid -> nasti_r_valid_o=0 those cycles, source 0 not granted.
